// File: rtl/demux8_16b_pkg.sv
// Shared sizing constants and helpers for the 8-channel, 16-bit routing demux.
package demux8_16b_pkg;

  localparam int NCH    = 8;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
  localparam int OCC_W  = 4;

  function automatic logic [OCC_W-1:0] popcnt_ch(input logic [NCH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux_slot_16b.sv
// One output channel: a single-entry word buffer with its full flag.
module demux_slot_16b
  import demux8_16b_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_out_ready,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  // A load on the same edge as a consume keeps the slot full with the new word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      r_full <= i_load | (r_full & ~i_out_ready);
      if (i_load) begin
        r_data <= i_data;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/demux8_16b.sv
// 1-to-8 demux of 16-bit words into one-entry channel buffers.
// Optional broadcast to all channels is compiled in with DEMUX_BCAST_EN.
module demux8_16b
  import demux8_16b_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      control,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
`ifdef DEMUX_BCAST_EN
  input  logic                  bcast,
`endif
  output logic [OCC_W-1:0]      occ
);

  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_room;
  logic [NCH-1:0]   w_cons;
  logic [NCH-1:0]   w_load;
  logic             w_bc;
  logic             w_accept;
  logic [OCC_W-1:0] w_inc;
  logic [OCC_W-1:0] w_dec;
  logic [OCC_W-1:0] r_occ;

  assign w_room = ~w_full | out_ready;
  assign w_cons = w_full & out_ready;

`ifdef DEMUX_BCAST_EN
  assign w_bc = in_valid & bcast;
`else
  assign w_bc = 1'b0;
`endif

  // Broadcast needs every channel free this cycle; control is then ignored.
  always_comb begin
    in_ready = w_bc ? (&w_room) : w_room[control];
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      if (w_bc) begin
        w_load = '1;
      end else begin
        w_load[control] = 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_slot
      demux_slot_16b u_slot (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load[g]),
        .i_data      (in_data),
        .i_out_ready (out_ready[g]),
        .o_full      (w_full[g]),
        .o_data      (out_data[g*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Loads into empty slots add one; consumes not refilled on the same edge remove one.
  assign w_inc = popcnt_ch(w_load & ~w_full);
  assign w_dec = popcnt_ch(w_cons & ~w_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + w_inc - w_dec;
    end
  end

  assign out_valid = w_full;
  assign occ       = r_occ;

endmodule

// File: tb/tb_demux8_16b.sv
// Randomized and directed bench for demux8_16b against a per-channel reference model.
module tb_demux8_16b;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_data;
  logic [2:0]   control;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [3:0]   occ;
  logic         bcast;

`ifdef DEMUX_BCAST_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  demux8_16b dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .control   (control),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX_BCAST_EN
    .bcast     (bcast),
`endif
    .occ       (occ)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which channels hold a word, and the word each lane shows.
  logic [7:0]  m_full;
  logic [15:0] m_data [8];
  logic        got_rdy;
  logic        exp_rdy;

  function automatic logic [15:0] lane(input int n);
    return out_data[16*n +: 16];
  endfunction

  task automatic model_clear();
    m_full = 8'h00;
    for (int i = 0; i < 8; i++) m_data[i] = 16'h0000;
  endtask

  task automatic do_cycle(input logic v, input logic [2:0] c, input logic [15:0] d,
                          input logic [7:0] r, input logic bc);
    logic bce;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    control   = c;
    in_data   = d;
    out_ready = r;
    bcast     = bc;
    #1;
    got_rdy = in_ready;
    bce = BC_EN && v && bc;
    if (bce) begin
      exp_rdy = 1'b1;
      for (int i = 0; i < 8; i++) if (m_full[i] && !r[i]) exp_rdy = 1'b0;
    end else begin
      exp_rdy = !m_full[c] || r[c];
    end
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (m_full[i] && r[i]) m_full[i] = 1'b0;
      if (acc && (bce || c == 3'(i))) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 8'h00; bcast = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; control = 3'd0; in_data = 16'h0;
    out_ready = 8'h00; bcast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h want 00", out_valid); end
    n_tests++;
    if (occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_tests++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_lanes got %h want 0", out_data); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 8; c++) begin
      control = 3'(c);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready ctrl %0d got %b want 1", c, in_ready); end
    end
  endtask

  task automatic test_single_route();
    apply_reset();
    do_cycle(1'b1, 3'd3, 16'hBEEF, 8'h00, 1'b0);
    n_tests++;
    if (got_rdy !== 1'b1) begin n_fail++; $display("FAIL route_ready got %b want 1", got_rdy); end
    n_tests++;
    if (out_valid !== 8'h08) begin n_fail++; $display("FAIL route_valid got %h want 08", out_valid); end
    n_tests++;
    if (lane(3) !== 16'hBEEF) begin n_fail++; $display("FAIL route_lane3 got %h want BEEF", lane(3)); end
    n_tests++;
    if (occ !== 4'd1) begin n_fail++; $display("FAIL route_occ got %0d want 1", occ); end
  endtask

  task automatic test_backpressure();
    do_cycle(1'b1, 3'd3, 16'h1234, 8'h00, 1'b0);
    n_tests++;
    if (got_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b want 0", got_rdy); end
    n_tests++;
    if (lane(3) !== 16'hBEEF) begin n_fail++; $display("FAIL bp_stall_lane3 got %h want BEEF", lane(3)); end
    do_cycle(1'b1, 3'd3, 16'h1234, 8'h08, 1'b0);
    n_tests++;
    if (got_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_go_ready got %b want 1", got_rdy); end
    n_tests++;
    if (lane(3) !== 16'h1234) begin n_fail++; $display("FAIL bp_go_lane3 got %h want 1234", lane(3)); end
    n_tests++;
    if (out_valid !== 8'h08 || occ !== 4'd1) begin
      n_fail++; $display("FAIL bp_go_state got %h/%0d want 08/1", out_valid, occ);
    end
  endtask

  task automatic test_fill_all();
    apply_reset();
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 3'(i), 16'hA000 + 16'(i), 8'h00, 1'b0);
    n_tests++;
    if (out_valid !== 8'hFF) begin n_fail++; $display("FAIL fill_valid got %h want FF", out_valid); end
    n_tests++;
    if (occ !== 4'd8) begin n_fail++; $display("FAIL fill_occ got %0d want 8", occ); end
    do_cycle(1'b0, 3'd0, 16'h0, 8'h20, 1'b0);
    n_tests++;
    if (out_valid !== 8'hDF) begin n_fail++; $display("FAIL drain5_valid got %h want DF", out_valid); end
    n_tests++;
    if (occ !== 4'd7) begin n_fail++; $display("FAIL drain5_occ got %0d want 7", occ); end
    n_tests++;
    if (lane(5) !== 16'hA005) begin n_fail++; $display("FAIL drain5_hold got %h want A005", lane(5)); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    do_cycle(1'b1, 3'd2, 16'h1111, 8'h00, 1'b0);
    do_cycle(1'b1, 3'd6, 16'h6666, 8'h00, 1'b0);
    do_cycle(1'b1, 3'd2, 16'h2222, 8'h04, 1'b0);
    n_tests++;
    if (lane(2) !== 16'h2222) begin n_fail++; $display("FAIL simul_lane2 got %h want 2222", lane(2)); end
    n_tests++;
    if (out_valid !== 8'h44) begin n_fail++; $display("FAIL simul_valid got %h want 44", out_valid); end
    n_tests++;
    if (occ !== 4'd2) begin n_fail++; $display("FAIL simul_occ got %0d want 2", occ); end
    do_cycle(1'b1, 3'd1, 16'h7777, 8'h40, 1'b0);
    n_tests++;
    if (out_valid !== 8'h06 || occ !== 4'd2) begin
      n_fail++; $display("FAIL indep_state got %h/%0d want 06/2", out_valid, occ);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 3'(i), 16'hC000 + 16'(i), 8'h00, 1'b0);
    n_tests++;
    if (occ !== 4'd5) begin n_fail++; $display("FAIL mid_pre_occ got %0d want 5", occ); end
    @(negedge clk);
    in_valid = 1'b1; control = 3'd6; in_data = 16'hDEAD; out_ready = 8'h01;
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 8'h00 || occ !== 4'd0 || out_data !== 128'h0) begin
      n_fail++; $display("FAIL mid_reset got %h/%0d/%h want 00/0/0", out_valid, occ, out_data);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 8'h00 || occ !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset_edge got %h/%0d want 00/0", out_valid, occ);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 8'h00;
    model_clear();
  endtask

  task automatic test_broadcast();
    apply_reset();
    do_cycle(1'b1, 3'd5, 16'h00A5, 8'h00, 1'b1);
    n_tests++;
    if (out_valid !== 8'hFF || occ !== 4'd8) begin
      n_fail++; $display("FAIL bc_fill got %h/%0d want FF/8", out_valid, occ);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (lane(i) !== 16'h00A5) begin n_fail++; $display("FAIL bc_lane%0d got %h want 00A5", i, lane(i)); end
    end
    do_cycle(1'b1, 3'd0, 16'h5A5A, 8'h7F, 1'b1);
    n_tests++;
    if (got_rdy !== 1'b0) begin n_fail++; $display("FAIL bc_stall_ready got %b want 0", got_rdy); end
    n_tests++;
    if (out_valid !== 8'h80 || occ !== 4'd1) begin
      n_fail++; $display("FAIL bc_stall_state got %h/%0d want 80/1", out_valid, occ);
    end
    do_cycle(1'b1, 3'd0, 16'h5A5A, 8'h80, 1'b1);
    n_tests++;
    if (got_rdy !== 1'b1) begin n_fail++; $display("FAIL bc_go_ready got %b want 1", got_rdy); end
    n_tests++;
    if (out_valid !== 8'hFF || occ !== 4'd8 || lane(0) !== 16'h5A5A || lane(7) !== 16'h5A5A) begin
      n_fail++; $display("FAIL bc_go_state got %h/%0d/%h want FF/8/5A5A", out_valid, occ, lane(0));
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [2:0] c;
    logic [7:0] r;
    logic       bc;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = 3'($urandom_range(0, 7));
      r  = 8'($urandom) & 8'($urandom);
      bc = BC_EN && ($urandom_range(0, 15) == 0);
      if (!v && $urandom_range(0, 3) == 0) c = 3'bxxx;
      do_cycle(v, c, 16'($urandom), r, bc);
      if (v) begin
        n_tests++;
        if (got_rdy !== exp_rdy) begin
          n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", k, got_rdy, exp_rdy);
        end
      end
      n_tests++;
      if (out_valid !== m_full) begin
        n_fail++; $display("FAIL rnd_valid cyc %0d got %h want %h", k, out_valid, m_full);
      end
      n_tests++;
      if (occ !== 4'($countones(m_full))) begin
        n_fail++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", k, occ, $countones(m_full));
      end
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (lane(i) !== m_data[i]) begin
          n_fail++; $display("FAIL rnd_lane%0d cyc %0d got %h want %h", i, k, lane(i), m_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_backpressure();
    test_fill_all();
    test_simultaneous();
    test_reset_mid();
    if (BC_EN) test_broadcast();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux8_16b.md
DEMUX8_16B -- requirements
Module: demux8_16b

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: in_data  input  16  word to be routed.
REQ-005 Port: control  input  3  destination channel index, 0..7 (channel 0 = A ... channel 7 = H).
REQ-006 Port: in_valid  input  1  in_data/control are valid this cycle.
REQ-007 Port: in_ready  output  1  the block accepts the offered word this cycle.
REQ-008 Port: out_data  output  8x16 (flattened 128, channel n at [16n+15:16n])  held word per channel.
REQ-009 Port: out_valid  output  8  channel n holds an unconsumed word.
REQ-010 Port: out_ready  input  8  consumer of channel n takes its word this cycle.
REQ-011 Port: occ  output  4  count of channels with out_valid set, 0..8.

Function
REQ-012 Each channel SHALL be a one-entry buffer with a full flag; out_valid[n] SHALL equal channel n's full flag.
REQ-013 Accept SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-014 in_ready SHALL equal (not full[control]) or out_ready[control], combinationally.
REQ-015 On accept, channel control SHALL load in_data and set full; out_data and out_valid SHALL update on that edge (one-cycle latency).
REQ-016 Consume SHALL occur when out_valid[n] and out_ready[n] are both 1 at an edge; full[n] SHALL clear unless the same edge accepts into channel n.
REQ-017 For a simultaneous consume and accept on the same channel, the new word SHALL replace the old one, full SHALL stay 1, and occ SHALL be unchanged.
REQ-018 Accepts into one channel and consumes on other channels in the same cycle SHALL be independent.
REQ-019 out_data[n] SHALL hold its value after a consume; only an accept changes it.
REQ-020 occ SHALL be a registered counter updated as occ + accept_new - consumes_that_empty. It SHALL always equal popcount(out_valid) and SHALL never exceed 8 or wrap.
REQ-021 When in_valid is 0, no channel SHALL change except through consumes.
REQ-022 X/unknown values on control while in_valid is 0 SHALL have no effect.

Reset
REQ-023 Asserting reset SHALL immediately clear out_valid to 8'h00, occ to 0, and every out_data lane to 16'h0000.
REQ-024 Reset asserted mid-transfer SHALL discard all held words, with no accept or consume on that edge.
REQ-025 On the first edge after reset deasserts, in_ready SHALL be 1 for any control value.

Configuration
REQ-026 Macro DEMUX_BCAST_EN SHALL compile in the broadcast feature.
REQ-027 With DEMUX_BCAST_EN defined, the block SHALL add the port bcast (input, 1 bit).
REQ-028 With DEMUX_BCAST_EN, when in_valid and bcast are both 1, in_ready SHALL be 1 only when every channel is empty or being consumed this cycle, and control is ignored.
REQ-029 With DEMUX_BCAST_EN, a broadcast accept SHALL load in_data into all 8 channels and set occ to 8.
REQ-030 Without DEMUX_BCAST_EN, the bcast port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-012..REQ-022.

Structure
REQ-031 A shared package SHALL define: the channel count (8), the data width (16), the select width (3), and the occ width (4).
REQ-032 Each channel SHALL be an instance of the sub-module demux_slot_16b, which holds the one-entry buffer, its full flag, and its load/consume logic.
REQ-033 The top level SHALL contain only the select decode, the in_ready mux, the broadcast logic, and the occ counter.

Verification
REQ-034 Single route: after reset, send in_data=16'hBEEF, control=3 with out_ready=0 -> next cycle out_valid=8'h08, lane 3=16'hBEEF, occ=1.
REQ-035 Backpressure: with channel 3 full and out_ready[3]=0, offer control=3 -> in_ready=0, lane 3 unchanged; raise out_ready[3] -> accept, and lane 3 = new word.
REQ-036 Fill all: accept 8 words to controls 0..7 with all out_ready=0 -> out_valid=8'hFF, occ=8; consume channel 5 only -> out_valid=8'hDF, occ=7.
REQ-037 Simultaneous: channel 2 full with 16'h1111; in one cycle consume channel 2 and accept 16'h2222 to control=2 -> lane 2=16'h2222, out_valid[2]=1, occ unchanged.
REQ-038 Reset mid-operation: with occ=5, pulse reset between clock edges -> out_valid=0, occ=0, all lanes 0 before the next edge.
REQ-039 Broadcast (DEMUX_BCAST_EN only): from empty, bcast=1 with in_data=16'h00A5 -> all lanes 16'h00A5, occ=8; a second broadcast stalls until all 8 channels are consumed.
